letter_wrap_shifter: RTL and testbench

Pipelined letter shifter that applies a keyed offset to uppercase ASCII letters (0x41–0x5A) and wraps any result past 'Z' or below 'A' back into the alphabet. It is the correcting counterpart of the overflow comparator: the comparator only detects an out-of-range value, and this block produces the in-range letter. It sits between the keyboard character source and the display/plugboard path. A rotor position counter advances the effective offset per letter, giving Enigma-style stepping.

---
 rtl/letter_wrap_shifter_if.sv | 23 ++
 rtl/letter_wrap_shifter.sv | 120 ++++++++++++
 tb/tb_letter_wrap_shifter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/letter_wrap_shifter_if.sv
// Handshake bundle for letter_wrap_shifter: input character channel and output letter channel.
interface letter_wrap_shifter_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       Gr;
    logic [4:0] key_offset;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;
    logic       out_wrapped;
    logic       out_nonletter;

    modport master (
        output in_valid, in_char, Gr, key_offset, out_ready,
        input  in_ready, out_valid, out_char, out_wrapped, out_nonletter
    );

    modport slave (
        input  in_valid, in_char, Gr, key_offset, out_ready,
        output in_ready, out_valid, out_char, out_wrapped, out_nonletter
    );
endinterface

// File: rtl/letter_wrap_shifter.sv
// Two-stage keyed letter shifter with A..Z wrap correction and a rotor position counter.
// Define ROTOR_STEP_EN to make the rotor position step per letter and feed the offset.
module letter_wrap_shifter (
    input  logic                  clk,
    input  logic                  reset,
    letter_wrap_shifter_if.slave  bus,
    input  logic                  load_pos,
    input  logic [4:0]            pos_init,
    output logic [4:0]            rotor_pos
);
    localparam logic [7:0] LETTER_A  = 8'h41;
    localparam logic [7:0] LETTER_Z  = 8'h5A;
    localparam int         ALPHA_LEN = 26;

    function automatic logic [4:0] mod_alpha(input logic [4:0] v);
        mod_alpha = (v >= 5'(ALPHA_LEN)) ? v - 5'(ALPHA_LEN) : v;
    endfunction

    function automatic logic [4:0] add_mod_alpha(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        add_mod_alpha = (sum >= 6'(ALPHA_LEN)) ? 5'(sum - 6'(ALPHA_LEN)) : sum[4:0];
    endfunction

    // Returns {wrapped, letter}; the raw shift stays within 0x28..0x73 so 8 bits suffice.
    function automatic logic [8:0] wrap_letter(input logic [7:0] ch, input logic gr,
                                               input logic [4:0] eff);
        logic [7:0] ntcv;
        ntcv = gr ? ch - {3'b000, eff} : ch + {3'b000, eff};
        if (!gr && ntcv > LETTER_Z)
            wrap_letter = {1'b1, ntcv - 8'(ALPHA_LEN)};
        else if (gr && ntcv < LETTER_A)
            wrap_letter = {1'b1, ntcv + 8'(ALPHA_LEN)};
        else
            wrap_letter = {1'b0, ntcv};
    endfunction

    logic       vld_p1, vld_p2;
    logic [7:0] char_p1, char_p2;
    logic       gr_p1, nonletter_p1;
    logic [4:0] eff_p1;
    logic       wrapped_p2, nonletter_p2;

    logic       adv_p2, in_fire, in_letter;
    logic [4:0] eff_in;
    logic [8:0] wrap_res;

    assign adv_p2       = !vld_p2 || bus.out_ready;
    assign bus.in_ready = !(vld_p1 && vld_p2 && !bus.out_ready);
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign in_letter    = (bus.in_char >= LETTER_A) && (bus.in_char <= LETTER_Z);

`ifdef ROTOR_STEP_EN
    assign eff_in = add_mod_alpha(mod_alpha(bus.key_offset), rotor_pos);

    // Load wins over a step; the accepted letter already used the old position above.
    always_ff @(posedge clk) begin
        if (reset)
            rotor_pos <= '0;
        else if (load_pos)
            rotor_pos <= mod_alpha(pos_init);
        else if (in_fire && in_letter)
            rotor_pos <= (rotor_pos == 5'(ALPHA_LEN - 1)) ? 5'd0 : rotor_pos + 5'd1;
    end
`else
    logic unused_pos_ctrl;
    assign eff_in          = mod_alpha(bus.key_offset);
    assign rotor_pos       = '0;
    assign unused_pos_ctrl = &{1'b0, load_pos, pos_init};
`endif

    // Stage 1: capture the character, direction and effective offset
    always_ff @(posedge clk) begin
        if (reset)
            vld_p1 <= 1'b0;
        else if (in_fire)
            vld_p1 <= 1'b1;
        else if (adv_p2)
            vld_p1 <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            char_p1      <= bus.in_char;
            gr_p1        <= bus.Gr;
            eff_p1       <= eff_in;
            nonletter_p1 <= !in_letter;
        end
    end

    assign wrap_res = wrap_letter(char_p1, gr_p1, eff_p1);

    // Stage 2: shift and wrap into the output register, held while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2       <= 1'b0;
            char_p2      <= 8'h00;
            wrapped_p2   <= 1'b0;
            nonletter_p2 <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                if (nonletter_p1) begin
                    char_p2      <= char_p1;
                    wrapped_p2   <= 1'b0;
                    nonletter_p2 <= 1'b1;
                end else begin
                    char_p2      <= wrap_res[7:0];
                    wrapped_p2   <= wrap_res[8];
                    nonletter_p2 <= 1'b0;
                end
            end
        end
    end

    assign bus.out_valid     = vld_p2;
    assign bus.out_char      = char_p2;
    assign bus.out_wrapped   = wrapped_p2;
    assign bus.out_nonletter = nonletter_p2;
endmodule

// File: tb/tb_letter_wrap_shifter.sv
// Randomized and directed bench for letter_wrap_shifter against an alphabet-arithmetic model.
module tb_letter_wrap_shifter;
    logic       clk;
    logic       reset;
    logic       load_pos;
    logic [4:0] pos_init;
    logic [4:0] rotor_pos;

    letter_wrap_shifter_if bus ();

    letter_wrap_shifter dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .load_pos  (load_pos),
        .pos_init  (pos_init),
        .rotor_pos (rotor_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pos      = 0;
    logic [9:0]  exp_q[$];
    logic [7:0]  out_log[$];
    logic        stall_prev = 1'b0;
    logic [9:0]  stall_data;
    logic        last_in_fire;
    logic        obs_valid, obs_ready, obs_wr, obs_nl;
    logic [7:0]  obs_char;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {nonletter, wrapped, char} from plain alphabet arithmetic
    function automatic logic [9:0] model(input int ch, input int gr, input int key, input int p);
        int eff, idx, s;
        if (ch < 65 || ch > 90) return {1'b1, 1'b0, 8'(ch)};
        eff = (key % 26 + p) % 26;
        idx = ch - 65;
        s   = gr ? idx - eff : idx + eff;
        return {1'b0, (s < 0 || s >= 26) ? 1'b1 : 1'b0, 8'(65 + (s + 26) % 26)};
    endfunction

    task automatic cycle(input logic v, input logic [7:0] ch, input logic g, input logic [4:0] k,
                         input logic ld, input logic [4:0] pi, input logic ordy, input logic rs);
        logic [9:0] e;
        bus.in_valid   = v;
        bus.in_char    = ch;
        bus.Gr         = g;
        bus.key_offset = k;
        bus.out_ready  = ordy;
        load_pos       = ld;
        pos_init       = pi;
        reset          = rs;
        #4;
        obs_valid    = bus.out_valid;
        obs_ready    = bus.in_ready;
        obs_char     = bus.out_char;
        obs_wr       = bus.out_wrapped;
        obs_nl       = bus.out_nonletter;
        last_in_fire = 1'b0;
        if (rs) begin
            exp_q.delete();
            pos        = 0;
            stall_prev = 1'b0;
        end else begin
            check_eq("rotor_pos", 32'(rotor_pos), 32'(pos));
            if (stall_prev) begin
                check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
                check_eq("hold_data", 32'({bus.out_nonletter, bus.out_wrapped, bus.out_char}),
                         32'(stall_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", 32'(bus.out_char), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_data", 32'({bus.out_nonletter, bus.out_wrapped, bus.out_char}),
                             32'(e));
                end
                out_log.push_back(bus.out_char);
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            stall_data = {bus.out_nonletter, bus.out_wrapped, bus.out_char};
            if (v && bus.in_ready) begin
                last_in_fire = 1'b1;
                exp_q.push_back(model(int'(ch), int'(g), int'(k), pos));
            end
`ifdef ROTOR_STEP_EN
            if (ld)
                pos = int'(pi) % 26;
            else if (last_in_fire && ch >= 8'h41 && ch <= 8'h5A)
                pos = (pos + 1) % 26;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    endtask

    // Load position 0, send one character, then wait until its output is presented.
    task automatic send1(input logic [7:0] ch, input logic g, input logic [4:0] k);
        cycle(1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        cycle(1'b1, ch, g, k, 1'b0, 5'd0, 1'b1, 1'b0);
        idle(2);
    endtask

    logic [7:0] bp_chars[4];
    int         idx;
    int         start_log;
    logic       v;
    logic [7:0] ch;

    initial begin
        bp_chars = '{8'h43, 8'h46, 8'h4B, 8'h51};
        cycle(1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);

        // Reset state
        idle(1);
        check_eq("rst_out_valid", 32'(obs_valid), 32'd0);
        check_eq("rst_out_char", 32'(obs_char), 32'h00);
        check_eq("rst_out_wrapped", 32'(obs_wr), 32'd0);
        check_eq("rst_out_nonletter", 32'(obs_nl), 32'd0);
        check_eq("rst_in_ready", 32'(obs_ready), 32'd1);
        check_eq("rst_rotor_pos", 32'(rotor_pos), 32'd0);

        // Forward without wrap and first-output latency
        cycle(1'b1, 8'h41, 1'b0, 5'd3, 1'b0, 5'd0, 1'b1, 1'b0);
        idle(1);
        check_eq("lat_not_early", 32'(obs_valid), 32'd0);
        idle(1);
        check_eq("lat_valid", 32'(obs_valid), 32'd1);
        check_eq("fwd_char", 32'(obs_char), 32'h44);
        check_eq("fwd_wrapped", 32'(obs_wr), 32'd0);
        idle(1);

        // Wrap both directions, reduced offset, non-letter
        send1(8'h59, 1'b0, 5'd3);
        check_eq("wrapf_char", 32'(obs_char), 32'h42);
        check_eq("wrapf_flag", 32'(obs_wr), 32'd1);
        send1(8'h42, 1'b1, 5'd3);
        check_eq("wrapr_char", 32'(obs_char), 32'h59);
        check_eq("wrapr_flag", 32'(obs_wr), 32'd1);
        send1(8'h59, 1'b0, 5'd29);
        check_eq("off29_char", 32'(obs_char), 32'h42);
        check_eq("off29_flag", 32'(obs_wr), 32'd1);
        send1(8'h21, 1'b0, 5'd5);
        check_eq("nonl_char", 32'(obs_char), 32'h21);
        check_eq("nonl_flag", 32'(obs_nl), 32'd1);
        check_eq("nonl_wrapped", 32'(obs_wr), 32'd0);
        check_eq("nonl_rotor", 32'(rotor_pos), 32'd0);

`ifdef ROTOR_STEP_EN
        // Stepping across the 25 -> 0 boundary
        out_log.delete();
        cycle(1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 5'd24, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h41, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        idle(3);
        check_eq("step_count", 32'(out_log.size()), 32'd3);
        check_eq("step_0", 32'(out_log[0]), 32'h59);
        check_eq("step_1", 32'(out_log[1]), 32'h5A);
        check_eq("step_2", 32'(out_log[2]), 32'h41);
        check_eq("step_rotor", 32'(rotor_pos), 32'd1);
`endif

        // Backpressure: 5 stalled cycles with 4 letters on offer
        out_log.delete();
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, bp_chars[idx % 4], 1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
            if (last_in_fire) idx++;
        end
        check_eq("bp_accepts", 32'(idx), 32'd2);
        check_eq("bp_in_ready", 32'(obs_ready), 32'd0);
        check_eq("bp_no_out", 32'(out_log.size()), 32'd0);
        for (int i = 0; i < 20; i++) begin
            cycle(idx < 4, bp_chars[idx % 4], 1'b0, 5'd7, 1'b0, 5'd0, 1'b1, 1'b0);
            if (last_in_fire) idx++;
        end
        check_eq("bp_out_count", 32'(out_log.size()), 32'd4);

        // Reset with two characters in flight
        out_log.delete();
        cycle(1'b1, 8'h4D, 1'b0, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0);
        cycle(1'b1, 8'h4E, 1'b0, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        idle(1);
        check_eq("mid_rst_valid", 32'(obs_valid), 32'd0);
        check_eq("mid_rst_ready", 32'(obs_ready), 32'd1);
        check_eq("mid_rst_rotor", 32'(rotor_pos), 32'd0);
        idle(3);
        check_eq("mid_rst_no_out", 32'(out_log.size()), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            ch = ($urandom_range(0, 9) < 8) ? 8'(65 + $urandom_range(0, 25)) : 8'($urandom_range(0, 255));
            cycle(v, ch, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 19) == 0), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) != 0), 1'b0);
        end
        idle(6);
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
